// File: rtl/histogram_stream.sv
// Per-frame grey-level histogram: counts pixels into 2**PIX_W saturating bins, then on the
// frame's last pixel streams every bin out (bin 0 first), clearing each bin as it is read.
module histogram_stream #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic [PIX_W-1:0] i,
  output logic [CNT_W-1:0] n_i,
  output logic             valid,
  output logic             last,
  output logic [CNT_W-1:0] total_px,
  output logic             busy
);

  localparam int NBINS = 2**PIX_W;

  typedef enum logic {ACCUM = 1'b0, DUMP = 1'b1} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] bins_q [NBINS];
  logic [CNT_W-1:0] cnt_q;
  logic [PIX_W:0]   idx_q;
  logic [PIX_W-1:0] i_q;
  logic [CNT_W-1:0] n_q;
  logic             valid_q;
  logic             last_q;
  logic [CNT_W-1:0] total_q;
  logic             busy_q;
  logic             ready_q;

  logic             accept;
  logic [PIX_W-1:0] idx_lo;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] bin_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign accept = pix_valid & ready_q;
  assign idx_lo = idx_q[PIX_W-1:0];
  assign cnt_d  = sat_inc(cnt_q);
  assign bin_d  = sat_inc(bins_q[pix]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      idx_q   <= '0;
      i_q     <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      total_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      for (int b = 0; b < NBINS; b++) bins_q[b] <= '0;
    end else if (state_q == ACCUM) begin
      if (accept) begin
        bins_q[pix] <= bin_d;
        if (pix_last) begin
          total_q <= cnt_d;
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= DUMP;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin
      // idx_q MSB set means every bin has been emitted; one extra edge closes the dump
      if (!idx_q[PIX_W]) begin
        i_q            <= idx_lo;
        n_q            <= bins_q[idx_lo];
        valid_q        <= 1'b1;
        last_q         <= &idx_lo;
        bins_q[idx_lo] <= '0;
        idx_q          <= idx_q + {{PIX_W{1'b0}}, 1'b1};
      end else begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        state_q <= ACCUM;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  assign pix_ready = ready_q;
  assign i         = i_q;
  assign n_i       = n_q;
  assign valid     = valid_q;
  assign last      = last_q;
  assign total_px  = total_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_histogram_stream.sv
// Scoreboard bench: two instances (CNT_W=32 and CNT_W=4) share one pixel stream; a
// counting model predicts every dumped bin, and a negedge monitor checks what comes out.
module tb_histogram_stream;

  localparam int NB = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pix;
  logic        pix_valid;
  logic        pix_last;

  logic        ready_a, valid_a, last_a, busy_a;
  logic [7:0]  i_a;
  logic [31:0] n_a, tot_a;
  logic        ready_b, valid_b, last_b, busy_b;
  logic [7:0]  i_b;
  logic [3:0]  n_b, tot_b;

  histogram_stream #(.PIX_W(8), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .pix(pix), .pix_valid(pix_valid), .pix_last(pix_last),
    .pix_ready(ready_a), .i(i_a), .n_i(n_a), .valid(valid_a), .last(last_a),
    .total_px(tot_a), .busy(busy_a));

  histogram_stream #(.PIX_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .pix(pix), .pix_valid(pix_valid), .pix_last(pix_last),
    .pix_ready(ready_b), .i(i_b), .n_i(n_b), .valid(valid_b), .last(last_b),
    .total_px(tot_b), .busy(busy_b));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  i;
    logic [31:0] n32;
    logic [3:0]  n4;
    logic        lst;
    logic [31:0] t32;
    logic [3:0]  t4;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference: true (unbounded) counts per grey level; saturation applied only when reported.
  longint unsigned hist[NB];
  longint unsigned total_true = 0;

  function automatic longint unsigned satw(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NB; k++) hist[k] = 0;
    total_true = 0;
  endtask

  task automatic push_dump(input int unsigned t);
    exp_t e;
    for (int k = 0; k < NB; k++) begin
      e.cyc = t + 1 + k;
      e.i   = 8'(k);
      e.n32 = 32'(satw(hist[k], 32));
      e.n4  = 4'(satw(hist[k], 4));
      e.lst = (k == NB - 1);
      e.t32 = 32'(satw(total_true, 32));
      e.t4  = 4'(satw(total_true, 4));
      q.push_back(e);
    end
    model_clear();
  endtask

  // Monitor: every valid beat must match the head of the queue, in the predicted cycle.
  always @(negedge clk) begin
    if (reset) begin
      chk("valid_b_matches_a", 64'(valid_b), 64'(valid_a));
      if (valid_a) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("dump_cycle", 64'(cyc), 64'(e.cyc));
          chk("i_a", 64'(i_a), 64'(e.i));
          chk("i_b", 64'(i_b), 64'(e.i));
          chk("n_a", 64'(n_a), 64'(e.n32));
          chk("n_b", 64'(n_b), 64'(e.n4));
          chk("last_a", 64'(last_a), 64'(e.lst));
          chk("last_b", 64'(last_b), 64'(e.lst));
          chk("total_a", 64'(tot_a), 64'(e.t32));
          chk("total_b", 64'(tot_b), 64'(e.t4));
          chk("busy_in_dump", 64'(busy_a), 64'(1));
          chk("ready_in_dump", 64'(ready_a), 64'(0));
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        chk("missing_valid_beat", 64'(q[0].cyc), 64'(cyc));
        void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] p, input logic l, input int idle,
                      output int stalls, output int unsigned t_acc);
    logic acc;
    pix_valid = 1'b0;
    repeat (idle) begin @(negedge clk); #1; end
    pix = p; pix_last = l; pix_valid = 1'b1; stalls = 0;
    forever begin
      acc   = ready_a;
      t_acc = cyc + 1;
      @(posedge clk);
      if (acc) break;
      stalls++;
      if (stalls > 2000) begin
        $display("FAIL accept_timeout: pixel never accepted after %0d cycles", stalls);
        $fatal(1);
      end
      @(negedge clk); #1;
    end
    hist[p]++;
    total_true++;
    if (l) push_dump(t_acc);
    @(negedge clk); #1;
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (q.size() > 0 && w < 2000) begin @(negedge clk); #1; w++; end
    chk("dump_drained", 64'(q.size()), 64'(0));
    q.delete();
    @(negedge clk); #1;
    chk("idle_ready", 64'(ready_a), 64'(1));
    chk("idle_busy", 64'(busy_a), 64'(0));
    chk("idle_valid", 64'(valid_a), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_i"}, 64'(i_a), 64'(0));
    chk({tag, "_n"}, 64'(n_a), 64'(0));
    chk({tag, "_valid"}, 64'(valid_a), 64'(0));
    chk({tag, "_last"}, 64'(last_a), 64'(0));
    chk({tag, "_total"}, 64'(tot_a), 64'(0));
    chk({tag, "_busy"}, 64'(busy_a), 64'(0));
    chk({tag, "_ready"}, 64'(ready_a), 64'(1));
    chk({tag, "_ready_b"}, 64'(ready_b), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    int unsigned t;
    int len;
    logic [7:0] pv;
    model_clear();
    reset = 1'b0; pix = '0; pix_valid = 1'b0; pix_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Frame 5,5,5,200(last)
    send(8'd5, 1'b0, 0, st, t);
    send(8'd5, 1'b0, 0, st, t);
    send(8'd5, 1'b0, 0, st, t);
    send(8'd200, 1'b1, 0, st, t);
    wait_idle();

    // 1000 back-to-back zeros
    for (int k = 0; k < 1000; k++) send(8'd0, (k == 999), 0, st, t);
    wait_idle();

    // 20 sevens: narrow instance saturates at 15
    for (int k = 0; k < 20; k++) send(8'd7, (k == 19), 0, st, t);
    wait_idle();

    // Frame A, then single-pixel frame 9 offered throughout A's dump
    for (int k = 0; k < 10; k++) send(8'($urandom_range(0, 255)), (k == 9), 0, st, t);
    send(8'd9, 1'b1, 0, st, t);
    chk("stall_during_dump", 64'(st), 64'(257));
    wait_idle();

    // Reset in the middle of a dump, at the edge that would present bin 100
    send(8'd150, 1'b0, 0, st, t);
    send(8'd50, 1'b0, 1, st, t);
    send(8'd200, 1'b1, 0, st, t);
    while (cyc != t + 100) begin @(negedge clk); #1; end
    while (q.size() > 0 && q[$].cyc >= t + 101) void'(q.pop_back());
    reset = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("mid_dump_reset");
    reset = 1'b1;
    model_clear();
    send(8'd3, 1'b0, 0, st, t);
    send(8'd3, 1'b1, 0, st, t);
    wait_idle();

    // Frame 1,2,2 with random idle gaps
    send(8'd1, 1'b0, $urandom_range(0, 4), st, t);
    send(8'd2, 1'b0, $urandom_range(0, 4), st, t);
    send(8'd2, 1'b1, $urandom_range(0, 4), st, t);
    wait_idle();

    // Random frames, including one-pixel frames
    for (int f = 0; f < 4; f++) begin
      len = (f == 0) ? 1 : $urandom_range(2, 40);
      for (int k = 0; k < len; k++) begin
        pv = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) pv = 8'd42;
        send(pv, (k == len - 1), $urandom_range(0, 2), st, t);
      end
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
